time_alarm_adjust: RTL and testbench
====================================

// Module: time_alarm_adjust
// PURPOSE
//   Timekeeping and adjust datapath downstream of the mode FSM. It counts
//   hh:mm:ss in run mode and applies up/down button pulses to the field that
//   the FSM mode selects. It holds the alarm time and raises the ring output
//   when the alarm time is reached. Its outputs feed the 7-seg display mux and the LEDs.
// PARAMETERS
//   HOURS      24   hour modulus; hours count 0..HOURS-1
//   RING_SECS  60   ring auto-timeout, counted in tick_1hz pulses
// PORTS
//   clk        in   1  system clock; the single clock domain of this block
//   rst        in   1  asynchronous, active-low reset
//   tick_1hz   in   1  one-clk-wide enable pulse, once per second
//   mode       in   3  000 run, 001 set time hour, 010 set time minute,
//                      011 set alarm hour, 100 set alarm minute
//   btn_up     in   1  one-clk pulse from the edge detector
//   btn_down   in   1  one-clk pulse from the edge detector
//   btn_stop   in   1  one-clk pulse; silences ring
//   alarm_en   in   1  level; 0 = alarm armed off
//   t_hh       out  5  time hours; reset 0
//   t_mm       out  6  time minutes; reset 0
//   t_ss       out  6  time seconds; reset 0
//   a_hh       out  5  alarm hours; reset 0
//   a_mm       out  6  alarm minutes; reset 0
//   ringing    out  1  alarm active; reset 0
//   blink      out  1  toggles on each tick while mode!=000, else 0; reset 0
// BEHAVIOUR
// - All registers update on posedge clk. rst=0 clears every output to 0
//   immediately, including mid-adjust or mid-ring.
// - Run (mode 000): on tick_1hz, ss increments. At 59, ss wraps to 0 and mm
//   increments. At mm 59 wrap, hh increments; HOURS-1 wraps to 0.
//   btn_up and btn_down are ignored in run mode.
// - Adjust (mode 001..100): the time counters are frozen and tick_1hz drives
//   only blink. Each btn_up / btn_down pulse changes the selected field by
//   +1 / -1 modulo its range: hours HOURS, minutes 60. The result is visible
//   the cycle after the pulse.
// - Adjusting t_mm also clears t_ss to 0 in the same cycle. Adjusting t_hh
//   leaves t_ss unchanged.
// - btn_up and btn_down asserted in the same cycle: no change.
// - Undefined mode codes (101..111): the block behaves as run mode.
// - Alarm match: in run mode, on the tick that makes t_ss 0 with
//   {t_hh,t_mm} == {a_hh,a_mm} after the update, and alarm_en=1, ringing is
//   set next cycle and the ring counter loads 0.
// - Ring: the ring counter increments on each tick. ringing clears on
//   btn_stop, on alarm_en=0, on leaving run mode, or when the counter reaches
//   RING_SECS. If a clear and a set occur in the same cycle, the clear wins.
// - blink is forced to 0 in the cycle mode returns to 000.
// - No latency other than the single register stage. Widths are fixed as
//   above; the internal ring counter is $clog2(RING_SECS+1) bits.
// TESTING
// 1. Reset then 3661 ticks in mode 000 -> t=01:01:01. Hold rst low
//    mid-count -> all outputs 0.
// 2. Preload 23:59:58 via adjust, then 2 ticks in run -> 00:00:00; next
//    tick -> 00:00:01.
// 3. mode 001 at hh=0, btn_down -> hh=23. btn_up and btn_down together ->
//    unchanged. 10 ticks in mode 001 -> t_ss frozen, blink toggles 10 times.
// 4. mode 010 at mm=59, ss=37, btn_up -> mm=0, ss=0, hh unchanged (no carry).
// 5. Alarm 07:30 with alarm_en=1, time 07:29:59, one tick -> ringing=1.
//    After 60 further ticks -> ringing=0. Repeat with btn_stop on tick 5 ->
//    ringing=0 on the next cycle.
// 6. Same as 5 but alarm_en=0 -> ringing stays 0. Ringing, then mode 001 ->
//    ringing=0 and blink active.

Source files
------------

// File: rtl/time_alarm_adjust_if.sv
`default_nettype none
// ============================================================================
// Module      : time_alarm_adjust_if
// Description : Bundle between the mode FSM / button conditioning and the
//               timekeeping datapath. The master drives mode, tick and
//               button pulses; the slave returns time, alarm, ring and blink.
//   tick_1hz  1  one-clk enable, once per second
//   mode      3  000 run, 001 t_hh, 010 t_mm, 011 a_hh, 100 a_mm
//   btn_up    1  one-clk increment pulse
//   btn_down  1  one-clk decrement pulse
//   btn_stop  1  one-clk ring silence pulse
//   alarm_en  1  level, alarm armed
//   t_hh/t_mm/t_ss, a_hh/a_mm, ringing, blink : datapath results
// Revision    : 1.0  initial release
// ============================================================================
interface time_alarm_adjust_if;
    logic       tick_1hz;
    logic [2:0] mode;
    logic       btn_up;
    logic       btn_down;
    logic       btn_stop;
    logic       alarm_en;
    logic [4:0] t_hh;
    logic [5:0] t_mm;
    logic [5:0] t_ss;
    logic [4:0] a_hh;
    logic [5:0] a_mm;
    logic       ringing;
    logic       blink;

    modport master (
        output tick_1hz, mode, btn_up, btn_down, btn_stop, alarm_en,
        input  t_hh, t_mm, t_ss, a_hh, a_mm, ringing, blink
    );

    modport slave (
        input  tick_1hz, mode, btn_up, btn_down, btn_stop, alarm_en,
        output t_hh, t_mm, t_ss, a_hh, a_mm, ringing, blink
    );
endinterface
`default_nettype wire

// File: rtl/time_alarm_adjust.sv
`default_nettype none
// ============================================================================
// Module      : time_alarm_adjust
// Description : hh:mm:ss timekeeping, field adjust via up/down pulses,
//               alarm compare with auto-timeout ring, and adjust-mode blink.
// Ports       : clk  - system clock
//               rst  - asynchronous active-low reset
//               bus  - time_alarm_adjust_if.slave (controls in, results out)
// Revision    : 1.0  initial release
// ============================================================================
module time_alarm_adjust #(
    parameter int HOURS     = 24,
    parameter int RING_SECS = 60
) (
    input  wire logic          clk,
    input  wire logic          rst,
    time_alarm_adjust_if.slave bus
);

    localparam int                c_RING_W   = $clog2(RING_SECS + 1);
    localparam logic [4:0]        c_HH_MAX   = 5'(HOURS - 1);
    localparam logic [5:0]        c_MS_MAX   = 6'd59;
    localparam logic [c_RING_W-1:0] c_RING_END = c_RING_W'(RING_SECS);
    localparam logic [c_RING_W-1:0] c_RING_ONE = c_RING_W'(1);

    localparam logic [2:0] c_MODE_RUN  = 3'b000;
    localparam logic [2:0] c_MODE_T_HH = 3'b001;
    localparam logic [2:0] c_MODE_T_MM = 3'b010;
    localparam logic [2:0] c_MODE_A_HH = 3'b011;
    localparam logic [2:0] c_MODE_A_MM = 3'b100;

    logic [4:0]          r_t_hh, w_t_hh_n;
    logic [5:0]          r_t_mm, w_t_mm_n;
    logic [5:0]          r_t_ss, w_t_ss_n;
    logic [4:0]          r_a_hh, w_a_hh_n;
    logic [5:0]          r_a_mm, w_a_mm_n;
    logic                r_ringing, w_ringing_n;
    logic                r_blink, w_blink_n;
    logic [c_RING_W-1:0] r_ring_cnt, w_ring_cnt_n;

    logic w_run;
    logic w_adj;
    logic w_ss_wrap;
    logic w_mm_wrap;
    logic w_ring_set;
    logic w_ring_tmo;
    logic w_ring_clr;

    // Modulo-60 step for minutes/seconds fields.
    function automatic logic [5:0] f_step60(input logic [5:0] v, input logic up);
        if (up) return (v == c_MS_MAX) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? c_MS_MAX : v - 6'd1;
    endfunction

    // Modulo-HOURS step for hour fields.
    function automatic logic [4:0] f_step_hh(input logic [4:0] v, input logic up);
        if (up) return (v == c_HH_MAX) ? 5'd0 : v + 5'd1;
        else    return (v == 5'd0) ? c_HH_MAX : v - 5'd1;
    endfunction

    always_comb begin
        w_t_hh_n     = r_t_hh;
        w_t_mm_n     = r_t_mm;
        w_t_ss_n     = r_t_ss;
        w_a_hh_n     = r_a_hh;
        w_a_mm_n     = r_a_mm;
        w_ringing_n  = r_ringing;
        w_ring_cnt_n = r_ring_cnt;
        w_blink_n    = 1'b0;
        w_ring_set   = 1'b0;
        w_ring_tmo   = 1'b0;

        // Codes above 100 are unassigned and fall back to run behaviour.
        w_run     = (bus.mode == c_MODE_RUN) || (bus.mode > c_MODE_A_MM);
        // Simultaneous up and down cancel out.
        w_adj     = bus.btn_up ^ bus.btn_down;
        w_ss_wrap = (r_t_ss == c_MS_MAX);
        w_mm_wrap = w_ss_wrap && (r_t_mm == c_MS_MAX);

        if (w_run) begin
            if (bus.tick_1hz) begin
                w_t_ss_n = w_ss_wrap ? 6'd0 : r_t_ss + 6'd1;
                if (w_ss_wrap) w_t_mm_n = f_step60(r_t_mm, 1'b1);
                if (w_mm_wrap) w_t_hh_n = f_step_hh(r_t_hh, 1'b1);
                // Match is judged on the post-update time, only at ss -> 0.
                w_ring_set = bus.alarm_en && w_ss_wrap &&
                             (w_t_hh_n == r_a_hh) && (w_t_mm_n == r_a_mm);
            end
        end else begin
            w_blink_n = bus.tick_1hz ? ~r_blink : r_blink;
            if (w_adj) begin
                case (bus.mode)
                    c_MODE_T_HH: w_t_hh_n = f_step_hh(r_t_hh, bus.btn_up);
                    c_MODE_T_MM: begin
                        w_t_mm_n = f_step60(r_t_mm, bus.btn_up);
                        w_t_ss_n = 6'd0;
                    end
                    c_MODE_A_HH: w_a_hh_n = f_step_hh(r_a_hh, bus.btn_up);
                    c_MODE_A_MM: w_a_mm_n = f_step60(r_a_mm, bus.btn_up);
                    default: ;
                endcase
            end
        end

        if (r_ringing && bus.tick_1hz) begin
            w_ring_cnt_n = r_ring_cnt + c_RING_ONE;
            w_ring_tmo   = ((r_ring_cnt + c_RING_ONE) == c_RING_END);
        end

        // Any clear source overrides a same-cycle set.
        w_ring_clr = bus.btn_stop || !bus.alarm_en || !w_run || w_ring_tmo;
        if (w_ring_clr) begin
            w_ringing_n = 1'b0;
        end else if (w_ring_set) begin
            w_ringing_n  = 1'b1;
            w_ring_cnt_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_t_hh     <= '0;
            r_t_mm     <= '0;
            r_t_ss     <= '0;
            r_a_hh     <= '0;
            r_a_mm     <= '0;
            r_ringing  <= 1'b0;
            r_blink    <= 1'b0;
            r_ring_cnt <= '0;
        end else begin
            r_t_hh     <= w_t_hh_n;
            r_t_mm     <= w_t_mm_n;
            r_t_ss     <= w_t_ss_n;
            r_a_hh     <= w_a_hh_n;
            r_a_mm     <= w_a_mm_n;
            r_ringing  <= w_ringing_n;
            r_blink    <= w_blink_n;
            r_ring_cnt <= w_ring_cnt_n;
        end
    end

    assign bus.t_hh    = r_t_hh;
    assign bus.t_mm    = r_t_mm;
    assign bus.t_ss    = r_t_ss;
    assign bus.a_hh    = r_a_hh;
    assign bus.a_mm    = r_a_mm;
    assign bus.ringing = r_ringing;
    assign bus.blink   = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_time_alarm_adjust.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_alarm_adjust
// Description : Directed stimulus for time_alarm_adjust. A seconds-of-day
//               model predicts every output each cycle; literal checks pin
//               the key scenario results.
// Revision    : 1.0  initial release
// ============================================================================
module tb_time_alarm_adjust;

    localparam int HOURS     = 24;
    localparam int RING_SECS = 60;
    localparam int DAY       = HOURS * 3600;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    time_alarm_adjust_if ifc ();

    time_alarm_adjust #(.HOURS(HOURS), .RING_SECS(RING_SECS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_secs = 0;   // time as seconds of day
    int m_amin = 0;   // alarm as minutes of day
    int m_ring = 0;
    int m_left = 0;   // ticks until ring auto-timeout
    int m_blink = 0;

    always @(posedge clk or negedge rst) begin
        int run, set, tmo, clr, d, h, m;
        if (!rst) begin
            m_secs = 0; m_amin = 0; m_ring = 0; m_left = 0; m_blink = 0;
        end else begin
            run = !(ifc.mode inside {3'd1, 3'd2, 3'd3, 3'd4});
            set = 0; tmo = 0;
            if (run) begin
                m_blink = 0;
                if (ifc.tick_1hz) begin
                    m_secs = (m_secs + 1) % DAY;
                    set = ifc.alarm_en && (m_secs % 60 == 0) && (m_secs / 60 == m_amin);
                end
            end else begin
                if (ifc.tick_1hz) m_blink = !m_blink;
                if (ifc.btn_up != ifc.btn_down) begin
                    d = ifc.btn_up ? 1 : -1;
                    case (ifc.mode)
                        3'd1: m_secs = (m_secs + d * 3600 + DAY) % DAY;
                        3'd2: begin
                            h = m_secs / 3600;
                            m = ((m_secs / 60) % 60 + d + 60) % 60;
                            m_secs = h * 3600 + m * 60;
                        end
                        3'd3: m_amin = (m_amin + d * 60 + HOURS * 60) % (HOURS * 60);
                        3'd4: begin
                            h = m_amin / 60;
                            m = (m_amin % 60 + d + 60) % 60;
                            m_amin = h * 60 + m;
                        end
                        default: ;
                    endcase
                end
            end
            if (m_ring && ifc.tick_1hz) begin
                m_left = m_left - 1;
                if (m_left == 0) tmo = 1;
            end
            clr = ifc.btn_stop || !ifc.alarm_en || !run || tmo;
            if (clr) m_ring = 0;
            else if (set) begin m_ring = 1; m_left = RING_SECS; end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        n_checks++;
        if (int'(ifc.t_hh) == m_secs / 3600 && int'(ifc.t_mm) == (m_secs / 60) % 60 &&
            int'(ifc.t_ss) == m_secs % 60 && int'(ifc.a_hh) == m_amin / 60 &&
            int'(ifc.a_mm) == m_amin % 60 && int'(ifc.ringing) == m_ring &&
            int'(ifc.blink) == m_blink)
            n_pass++;
        else
            $display("FAIL cycle @%0t: got %0d:%0d:%0d a=%0d:%0d r=%0b b=%0b want %0d:%0d:%0d a=%0d:%0d r=%0d b=%0d",
                     $time, ifc.t_hh, ifc.t_mm, ifc.t_ss, ifc.a_hh, ifc.a_mm, ifc.ringing, ifc.blink,
                     m_secs / 3600, (m_secs / 60) % 60, m_secs % 60, m_amin / 60, m_amin % 60,
                     m_ring, m_blink);
    end

    // ---------------- literal checks & stimulus ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, got, exp);
    endtask

    task automatic chk_time(input string name, input int hh, input int mm, input int ss);
        chk({name, "_hh"}, int'(ifc.t_hh), hh);
        chk({name, "_mm"}, int'(ifc.t_mm), mm);
        chk({name, "_ss"}, int'(ifc.t_ss), ss);
    endtask

    // One cycle: apply pulses at a falling edge, release at the next one.
    task automatic drive(input logic tk, input logic up, input logic dn, input logic stp);
        ifc.tick_1hz = tk; ifc.btn_up = up; ifc.btn_down = dn; ifc.btn_stop = stp;
        @(negedge clk);
        ifc.tick_1hz = 1'b0; ifc.btn_up = 1'b0; ifc.btn_down = 1'b0; ifc.btn_stop = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ups(input int n);
        repeat (n) drive(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic downs(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic prev;
        int   tog;
        ifc.tick_1hz = 1'b0; ifc.mode = 3'd0; ifc.btn_up = 1'b0;
        ifc.btn_down = 1'b0; ifc.btn_stop = 1'b0; ifc.alarm_en = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_time("reset", 0, 0, 0);
        chk("reset_ring", int'(ifc.ringing), 0);
        chk("reset_blink", int'(ifc.blink), 0);
        rst = 1'b1;
        @(negedge clk);

        // 1. 3661 ticks -> 01:01:01, then asynchronous reset mid-count
        ticks(3661);
        chk_time("count3661", 1, 1, 1);
        ticks(5);
        rst = 1'b0;
        #1;
        chk_time("async_rst", 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 2. preload 23:59:58 and roll over midnight
        ifc.mode = 3'd1; downs(1);
        ifc.mode = 3'd2; downs(1);
        ifc.mode = 3'd0; ticks(58);
        chk_time("preload", 23, 59, 58);
        ticks(2);
        chk_time("midnight", 0, 0, 0);
        ticks(1);
        chk_time("after_mid", 0, 0, 1);

        // 3. hour wrap down, cancelling pulses, frozen time with blink
        ifc.mode = 3'd1; downs(1);
        chk("hh_wrap_down", int'(ifc.t_hh), 23);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("up_dn_cancel", int'(ifc.t_hh), 23);
        prev = ifc.blink; tog = 0;
        repeat (10) begin
            ticks(1);
            if (ifc.blink != prev) tog++;
            prev = ifc.blink;
        end
        chk("frozen_ss", int'(ifc.t_ss), 1);
        chk("blink_toggles", tog, 10);

        // 4. minute wrap up clears seconds without hour carry
        ifc.mode = 3'd2; downs(1);
        ifc.mode = 3'd0; ticks(37);
        chk_time("pre_mm_wrap", 23, 59, 37);
        ifc.mode = 3'd2; ups(1);
        chk_time("mm_wrap", 23, 0, 0);

        // 5. alarm 07:30 rings, times out after 60 ticks; then btn_stop
        ifc.mode = 3'd3; ups(7);
        ifc.mode = 3'd4; ups(30);
        chk("alarm_hh", int'(ifc.a_hh), 7);
        chk("alarm_mm", int'(ifc.a_mm), 30);
        ifc.mode = 3'd1; ups(8);
        ifc.mode = 3'd2; ups(29);
        ifc.alarm_en = 1'b1;
        ifc.mode = 3'd0; ticks(59);
        chk_time("pre_alarm", 7, 29, 59);
        ticks(1);
        chk("ring_on", int'(ifc.ringing), 1);
        ticks(59);
        chk("ring_59", int'(ifc.ringing), 1);
        ticks(1);
        chk("ring_tmo", int'(ifc.ringing), 0);
        ifc.mode = 3'd2; downs(2);
        ifc.mode = 3'd0; ticks(60);
        chk("ring_on2", int'(ifc.ringing), 1);
        ticks(4);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        chk("ring_stop", int'(ifc.ringing), 0);

        // 6. disarmed alarm, and leaving run mode while ringing
        ifc.mode = 3'd2; downs(1);
        ifc.mode = 3'd0; ticks(59);
        ifc.alarm_en = 1'b0;
        ticks(1);
        chk("ring_disarmed", int'(ifc.ringing), 0);
        ifc.alarm_en = 1'b1;
        ifc.mode = 3'd2; downs(1);
        ifc.mode = 3'd0; ticks(60);
        chk("ring_on3", int'(ifc.ringing), 1);
        ifc.mode = 3'd1; ticks(1);
        chk("ring_mode_exit", int'(ifc.ringing), 0);
        chk("blink_adjust", int'(ifc.blink), 1);
        ifc.mode = 3'd0; drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("blink_run_clr", int'(ifc.blink), 0);

        // undefined mode code counts like run
        ifc.mode = 3'd5; ticks(3);
        chk_time("mode5_run", 7, 30, 3);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
